// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared definitions for the VGA test-pattern path.
//            - Pattern codes (3-bit) selected through i_Pattern.
//            - Default 640x480 timing constants (visible and total).
//            - Colour-bar order as {R,G,B} on/off masks, plus a helper
//              that maps a bar index (0 = leftmost) to its mask.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  typedef enum logic [2:0] {
    PATTERN_BLACK      = 3'd0,
    PATTERN_RED        = 3'd1,
    PATTERN_GREEN      = 3'd2,
    PATTERN_BLUE       = 3'd3,
    PATTERN_CHECKER    = 3'd4,
    PATTERN_BARS       = 3'd5,
    PATTERN_BORDER     = 3'd6,
    PATTERN_MOVING_BAR = 3'd7
  } pattern_e;

  localparam int DEFAULT_ACTIVE_COLS = 640;
  localparam int DEFAULT_ACTIVE_ROWS = 480;
  localparam int DEFAULT_TOTAL_COLS  = 800;
  localparam int DEFAULT_TOTAL_ROWS  = 525;

  localparam int NUM_BARS = 8;

  // Colour masks, bit order {R,G,B}; each set bit drives that channel full.
  localparam logic [2:0] COLOUR_WHITE   = 3'b111;
  localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOUR_CYAN    = 3'b011;
  localparam logic [2:0] COLOUR_GREEN   = 3'b010;
  localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOUR_RED     = 3'b100;
  localparam logic [2:0] COLOUR_BLUE    = 3'b001;
  localparam logic [2:0] COLOUR_BLACK   = 3'b000;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = COLOUR_WHITE;
      3'd1:    bar_colour = COLOUR_YELLOW;
      3'd2:    bar_colour = COLOUR_CYAN;
      3'd3:    bar_colour = COLOUR_GREEN;
      3'd4:    bar_colour = COLOUR_MAGENTA;
      3'd5:    bar_colour = COLOUR_RED;
      3'd6:    bar_colour = COLOUR_BLUE;
      default: bar_colour = COLOUR_BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_delay
// Purpose  : Fixed-depth shift register for the {HSync,VSync} pair so the
//            syncs stay pixel-aligned with the pipelined RGB. Every stage
//            resets to 1 (syncs are active low, so reset means "idle").
// Ports    : i_Clk    pixel clock
//            i_Reset  synchronous reset, active high
//            i_Sync   {HSync,VSync} in
//            o_Sync   {HSync,VSync} delayed DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [1:0] i_Sync,
  output logic [1:0] o_Sync
);

  logic [1:0] pipe [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= 2'b11;
      end
    end else begin
      pipe[0] <= i_Sync;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign o_Sync = pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_test_pattern_gen
// Purpose  : Display bring-up pattern source. Consumes the sync generator's
//            HSync/VSync and column/row counts and produces RGB for the VGA
//            DAC, two cycles after the input pixel, with syncs delayed by the
//            same amount. Patterns: black, red, green, blue, checker, eight
//            colour bars, one-pixel border, and a bar that moves one column
//            per frame.
// Ports    : i_Clk        pixel clock
//            i_Reset      synchronous reset, active high
//            i_HSync      horizontal sync in (active low, passed through)
//            i_VSync      vertical sync in (active low, passed through)
//            i_Col_Count  current column
//            i_Row_Count  current row
//            i_Pattern    pattern select, taken only at frame start
//            o_HSync      i_HSync delayed 2 cycles
//            o_VSync      i_VSync delayed 2 cycles
//            o_Red/o_Grn/o_Blu  colour channels, VIDEO_WIDTH bits each
// Revision : 1.0 - initial release
// ============================================================================
module vga_test_pattern_gen
  import vga_pkg::*;
#(
  parameter int VIDEO_WIDTH = 3,
  parameter int ACTIVE_COLS = DEFAULT_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEFAULT_ACTIVE_ROWS,
  parameter int BAR_WIDTH   = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [9:0]             i_Col_Count,
  input  logic [9:0]             i_Row_Count,
  input  logic [2:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu
);

  localparam logic [9:0]  COLS_C     = 10'(ACTIVE_COLS);
  localparam logic [9:0]  ROWS_C     = 10'(ACTIVE_ROWS);
  localparam logic [9:0]  LAST_COL   = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0]  LAST_ROW   = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0]  BAR_LAST   = 10'(ACTIVE_COLS - BAR_WIDTH);
  localparam logic [10:0] BAR_W_C    = 11'(BAR_WIDTH);
  localparam int          BAR_STEP   = ACTIVE_COLS / NUM_BARS;
  localparam logic [VIDEO_WIDTH-1:0] FULL = {VIDEO_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // Frame-start bookkeeping. The bar advances based on the pattern that was
  // in force for the frame just finished, so a freshly selected pattern 7
  // starts its first frame at the current position.
  // --------------------------------------------------------------------------
  logic     frame_start;
  pattern_e pattern_q;
  logic [9:0] bar_pos;

  assign frame_start = (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pattern_q <= PATTERN_BLACK;
      bar_pos   <= '0;
    end else if (frame_start) begin
      pattern_q <= pattern_e'(i_Pattern);
      if (pattern_q == PATTERN_MOVING_BAR) begin
        bar_pos <= (bar_pos == BAR_LAST) ? 10'd0 : bar_pos + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: register position and active-area flag.
  // --------------------------------------------------------------------------
  logic [9:0] col_s1;
  logic [9:0] row_s1;
  logic       active_s1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_s1    <= '0;
      row_s1    <= '0;
      active_s1 <= 1'b0;
    end else begin
      col_s1    <= i_Col_Count;
      row_s1    <= i_Row_Count;
      active_s1 <= (i_Col_Count < COLS_C) && (i_Row_Count < ROWS_C);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pattern decode to an {R,G,B} on/off mask, then register.
  // --------------------------------------------------------------------------
  logic [2:0] bar_idx;
  logic [2:0] rgb_mask;
  logic       in_moving_bar;
  logic       on_border;

  // Compare chain against fixed bar edges instead of dividing the column.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (col_s1 >= 10'(i * BAR_STEP)) begin
        bar_idx = 3'(i);
      end
    end
  end

  assign in_moving_bar = ({1'b0, col_s1} >= {1'b0, bar_pos}) &&
                         ({1'b0, col_s1} <  ({1'b0, bar_pos} + BAR_W_C));

  assign on_border = (col_s1 == 10'd0) || (col_s1 == LAST_COL) ||
                     (row_s1 == 10'd0) || (row_s1 == LAST_ROW);

  always_comb begin
    rgb_mask = COLOUR_BLACK;
    case (pattern_q)
      PATTERN_BLACK:      rgb_mask = COLOUR_BLACK;
      PATTERN_RED:        rgb_mask = COLOUR_RED;
      PATTERN_GREEN:      rgb_mask = COLOUR_GREEN;
      PATTERN_BLUE:       rgb_mask = COLOUR_BLUE;
      PATTERN_CHECKER:    rgb_mask = (col_s1[5] ^ row_s1[5]) ? COLOUR_WHITE : COLOUR_BLACK;
      PATTERN_BARS:       rgb_mask = bar_colour(bar_idx);
      PATTERN_BORDER:     rgb_mask = on_border ? COLOUR_WHITE : COLOUR_BLACK;
      PATTERN_MOVING_BAR: rgb_mask = in_moving_bar ? COLOUR_WHITE : COLOUR_BLACK;
      default:            rgb_mask = COLOUR_BLACK;
    endcase
    if (!active_s1) begin
      rgb_mask = COLOUR_BLACK;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Red <= '0;
      o_Grn <= '0;
      o_Blu <= '0;
    end else begin
      o_Red <= rgb_mask[2] ? FULL : '0;
      o_Grn <= rgb_mask[1] ? FULL : '0;
      o_Blu <= rgb_mask[0] ? FULL : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Syncs: pure delay, polarity untouched.
  // --------------------------------------------------------------------------
  logic [1:0] sync_out;

  vga_sync_delay #(
    .DEPTH (2)
  ) u_sync_delay (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sync  ({i_HSync, i_VSync}),
    .o_Sync  (sync_out)
  );

  assign o_HSync = sync_out[1];
  assign o_VSync = sync_out[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_test_pattern_gen
// Purpose  : Self-checking bench. The driver applies one pixel per clock and
//            pushes the expected output for that pixel into a queue, computed
//            from a frame-level model (pattern and bar position updated at
//            each frame start, colours from plain arithmetic). The monitor
//            pops on the falling edge and compares against the DUT outputs.
// Revision : 1.1 - reset-state and timeout checks
// ============================================================================
module tb_vga_test_pattern_gen;

    localparam int W  = 3;
    localparam int AC = 640;
    localparam int AR = 480;
    localparam int BW = 16;
    localparam int FULLV = (1 << W) - 1;
    localparam int TIMEOUT_CYCLES = 2000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         hs_in, vs_in;
    logic [9:0]   col_in, row_in;
    logic [2:0]   pat_in;
    logic         hs_out, vs_out;
    logic [W-1:0] red, grn, blu;

    vga_test_pattern_gen #(
        .VIDEO_WIDTH (W),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .BAR_WIDTH   (BW)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_HSync     (hs_in),
        .i_VSync     (vs_in),
        .i_Col_Count (col_in),
        .i_Row_Count (row_in),
        .i_Pattern   (pat_in),
        .o_HSync     (hs_out),
        .o_VSync     (vs_out),
        .o_Red       (red),
        .o_Grn       (grn),
        .o_Blu       (blu)
    );

    typedef struct {
        bit rst;
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    string phase  = "init";
    bit    done   = 1'b0;

    int m_pat = 0;
    int m_bar = 0;

    function automatic int model_mask(int c, int r, int p, int bar);
        int bar_tab[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
        if (c >= AC || r >= AR) return 0;
        case (p)
            1: return 4;
            2: return 2;
            3: return 1;
            4: return ((((c / 32) % 2) != ((r / 32) % 2))) ? 7 : 0;
            5: return bar_tab[c / (AC / 8)];
            6: return (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) ? 7 : 0;
            7: return (c >= bar && c < bar + BW) ? 7 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic drive_raw(bit rs, int c, int r, int p, bit h, bit v);
        exp_t e;
        int   m;
        rst    = rs;
        col_in = 10'(c);
        row_in = 10'(r);
        pat_in = 3'(p);
        hs_in  = h;
        vs_in  = v;
        e.rst = rs;
        if (rs) begin
            m_pat = 0;
            m_bar = 0;
            e.hs = 1'b1; e.vs = 1'b1; e.r = 0; e.g = 0; e.b = 0;
        end else begin
            if (c == 0 && r == 0) begin
                if (m_pat == 7) m_bar = (m_bar + 1) % (AC - BW + 1);
                m_pat = p;
            end
            m = model_mask(c, r, m_pat, m_bar);
            e.hs = h; e.vs = v;
            e.r = ((m & 4) != 0) ? FULLV : 0;
            e.g = ((m & 2) != 0) ? FULLV : 0;
            e.b = ((m & 1) != 0) ? FULLV : 0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit rs, int c, int r, int p);
        drive_raw(rs, c, r, p, !(c >= 656 && c < 752), !(r >= 490 && r < 492));
    endtask

    always @(negedge clk) begin
        if (q.size() >= 3) begin
            exp_t e;
            bit   blank;
            e = q.pop_front();
            blank = e.rst || q[0].rst;
            if (blank) begin
                e.hs = 1'b1; e.vs = 1'b1; e.r = 0; e.g = 0; e.b = 0;
            end
            checks++;
            if (hs_out !== e.hs || vs_out !== e.vs || int'(red) != e.r ||
                int'(grn) != e.g || int'(blu) != e.b ||
                $isunknown({hs_out, vs_out, red, grn, blu})) begin
                errors++;
                $display("FAIL %s: got hs=%b vs=%b rgb=%0d/%0d/%0d, expected hs=%b vs=%b rgb=%0d/%0d/%0d",
                         phase, hs_out, vs_out, red, grn, blu, e.hs, e.vs, e.r, e.g, e.b);
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not finish within %0d cycles (phase %s)",
                     TIMEOUT_CYCLES, phase);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        int border_rows[6] = '{0, 1, 240, 478, 479, 480};
        int border_cols[7] = '{0, 1, 320, 638, 639, 640, 799};
        int offs[6]        = '{-1, 0, 1, 15, 16, 17};

        phase = "reset";
        repeat (5) drive(1, 0, 0, 1);
        checks++;
        if (hs_out !== 1'b1 || vs_out !== 1'b1 || red !== '0 || grn !== '0 || blu !== '0) begin
            errors++;
            $display("FAIL reset_state: got hs=%b vs=%b rgb=%0d/%0d/%0d, expected hs=1 vs=1 rgb=0/0/0",
                     hs_out, vs_out, red, grn, blu);
        end

        phase = "release_red";
        drive(0, 0, 0, 1);
        for (int c = 1; c < 20; c++) drive(0, c, 0, 1);

        phase = "colour_bars";
        drive(0, 0, 0, 5);
        for (int c = 0; c < 800; c++) drive(0, c, 10, 5);

        phase = "pattern_switch";
        drive(0, 0, 0, 1);
        for (int r = 50; r <= 200; r += 50)
            for (int c = 0; c < 700; c += 70) drive(0, c, r, (r >= 100) ? 3 : 1);
        drive(0, 0, 0, 3);
        for (int c = 1; c < 10; c++) drive(0, c * 60, 5, 1);

        phase = "border";
        drive(0, 0, 0, 6);
        foreach (border_rows[i])
            foreach (border_cols[j]) drive(0, border_cols[j], border_rows[i], 6);
        drive(0, 320, 240, 6);

        phase = "checker";
        drive(0, 0, 0, 4);
        repeat (200) drive(0, $urandom_range(0, 799), $urandom_range(0, 524), 4);

        phase = "moving_bar";
        for (int f = 0; f < 700; f++) begin
            drive(0, 0, 0, 7);
            foreach (offs[k]) begin
                int c;
                c = m_bar + offs[k];
                if (c < 0) c = 0;
                drive(0, c, 3, 7);
            end
        end

        phase = "mid_reset";
        drive(0, 0, 0, 2);
        for (int c = 0; c < 10; c++) drive(0, c * 10, 50, 2);
        repeat (3) drive(1, 100, 50, 2);
        for (int c = 101; c < 110; c++) drive(0, c, 50, 2);
        drive(0, 0, 0, 2);
        for (int c = 1; c < 10; c++) drive(0, c * 10, 7, 2);

        phase = "random";
        repeat (1500) begin
            bit rs;
            int c, r;
            rs = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) begin
                c = 0; r = 0;
            end else begin
                c = $urandom_range(0, 799);
                r = $urandom_range(0, 524);
            end
            drive_raw(rs, c, r, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
        end

        phase = "flush";
        repeat (4) drive(0, 700, 500, 0);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
